// File: rtl/adapter_n_to_1_serializer.sv
// N-lane to 1-word serializer: captures a packed bus of lanes plus an enable
// mask, then emits the enabled lanes lowest-index first on a valid/ready stream.
module adapter_n_to_1_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4,
    parameter int IDX_WIDTH  = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_mask,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]           out_index,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [N_INPUTS*DATA_WIDTH-1:0] r_hold;
    logic [N_INPUTS*DATA_WIDTH-1:0] w_hold_nxt;
    logic [N_INPUTS-1:0]            r_pend;
    logic [N_INPUTS-1:0]            w_pend_nxt;
    logic [N_INPUTS-1:0]            w_pend_rest;
    logic [IDX_WIDTH-1:0]           w_sel_idx;
    logic [DATA_WIDTH-1:0]          w_sel_data;
    logic                           w_send;
    logic                           w_last;
    logic                           w_xfer;
    logic                           w_accept;
    logic                           w_load;

    // Lowest set pending bit selects the lane; descending scan lets the lowest win.
    always_comb begin
        w_sel_idx  = {IDX_WIDTH{1'b0}};
        w_sel_data = {DATA_WIDTH{1'b0}};
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            w_sel_idx  = r_pend[i] ? IDX_WIDTH'(i) : w_sel_idx;
            w_sel_data = r_pend[i] ? r_hold[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_data;
        end
    end

    // Handshake decode; clearing the lowest set bit gives the post-transfer mask.
    always_comb begin
        w_pend_rest = r_pend & (r_pend - N_INPUTS'(1));
        w_send      = (r_state == ST_SEND);
        w_last      = w_send && (w_pend_rest == {N_INPUTS{1'b0}});
        w_xfer      = w_send && out_ready;
        in_ready    = reset_L && (!w_send || (w_xfer && w_last));
        w_accept    = in_valid && in_ready;
        w_load      = w_accept && (in_mask != {N_INPUTS{1'b0}});
        out_valid   = w_send;
        out_last    = w_last;
        busy        = w_send;
        out_data    = w_send ? w_sel_data : {DATA_WIDTH{1'b0}};
        out_index   = w_send ? w_sel_idx : {IDX_WIDTH{1'b0}};
    end

    // Next-state: a load (only possible when idle or on the final transfer) wins.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = w_load ? in_data : r_hold;
        w_pend_nxt  = w_load ? in_mask : (w_xfer ? w_pend_rest : r_pend);
        case (r_state)
            ST_IDLE: w_state_nxt = w_load ? ST_SEND : ST_IDLE;
            ST_SEND: w_state_nxt = w_load ? ST_SEND :
                                   ((w_xfer && w_last) ? ST_IDLE : ST_SEND);
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = {N_INPUTS{1'b0}};
            end
        endcase
    end

    // State, holding and pending-mask registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
            r_hold  <= {(N_INPUTS*DATA_WIDTH){1'b0}};
            r_pend  <= {N_INPUTS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

endmodule

// File: tb/tb_adapter_n_to_1_serializer.sv
// Directed bench for adapter_n_to_1_serializer: a 16x4 instance plus an 8x3 instance.
module tb_adapter_n_to_1_serializer;

    logic        clk;
    logic        reset_L;
    logic [63:0] in_data;
    logic [3:0]  in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [23:0] p_in_data;
    logic [2:0]  p_in_mask;
    logic        p_in_valid;
    logic        p_in_ready;
    logic [7:0]  p_out_data;
    logic [1:0]  p_out_index;
    logic        p_out_last;
    logic        p_out_valid;
    logic        p_out_ready;
    logic        p_busy;

    int n_pass;
    int n_total;

    localparam logic [63:0] BUS_A = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    localparam logic [63:0] BUS_B = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] exp_a [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] exp_b [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

    adapter_n_to_1_serializer #(.DATA_WIDTH(16), .N_INPUTS(4)) u_dut (
        .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_mask(in_mask),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    adapter_n_to_1_serializer #(.DATA_WIDTH(8), .N_INPUTS(3)) u_dut3 (
        .clk(clk), .reset_L(reset_L), .in_data(p_in_data), .in_mask(p_in_mask),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .out_data(p_out_data),
        .out_index(p_out_index), .out_last(p_out_last), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .busy(p_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset_L = 1'b0;
        in_data = 64'h0; in_mask = 4'h0; in_valid = 1'b0; out_ready = 1'b1;
        p_in_data = 24'h0; p_in_mask = 3'h0; p_in_valid = 1'b0; p_out_ready = 1'b1;
        #3;
        n_total++;
        if ({out_valid, out_data, out_index, out_last, busy, in_ready} !== 22'h0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {out_valid, out_data, out_index, out_last, busy, in_ready});
        else n_pass++;
        n_total++;
        if ({p_out_valid, p_out_data, p_out_index, p_out_last, p_busy, p_in_ready} !== 14'h0)
            $display("FAIL reset_outputs_p: got %h, expected 0",
                     {p_out_valid, p_out_data, p_out_index, p_out_last, p_busy, p_in_ready});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk); #2;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_release: got %b, expected 100", {in_ready, out_valid, busy});
        else n_pass++;
    endtask

    task automatic test_full_mask();
        in_data = BUS_A; in_mask = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if ({out_valid, out_data, out_index, out_last, busy} !==
                {1'b1, exp_a[k], 2'(k), (k == 3), 1'b1})
                $display("FAIL full_word%0d: got v=%b d=%h i=%0d l=%b b=%b, expected d=%h i=%0d",
                         k, out_valid, out_data, out_index, out_last, busy, exp_a[k], k);
            else n_pass++;
            @(posedge clk); #2;
        end
        n_total++;
        if ({out_valid, busy, out_data, out_index} !== 20'h0)
            $display("FAIL full_done: got v=%b b=%b d=%h, expected idle zeros", out_valid, busy, out_data);
        else n_pass++;
    endtask

    task automatic test_sparse();
        in_data = {16'h0123, 16'h00BB, 16'h0AAA, 16'hAAAA};
        in_mask = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; #1;
        n_total++;
        if ({out_valid, out_data, out_index, out_last} !== {1'b1, 16'h0AAA, 2'd1, 1'b0})
            $display("FAIL sparse_w0: got d=%h i=%0d l=%b, expected 0aaa 1 0", out_data, out_index, out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if ({out_valid, out_data, out_index, out_last} !== {1'b1, 16'h0123, 2'd3, 1'b1})
            $display("FAIL sparse_w1: got d=%h i=%0d l=%b, expected 0123 3 1", out_data, out_index, out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL sparse_done: got v=%b b=%b, expected 0 0", out_valid, busy);
        else n_pass++;
        in_mask = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({out_valid, busy, in_ready} !== 3'b001)
                $display("FAIL zero_mask%0d: got v=%b b=%b r=%b, expected 0 0 1", k, out_valid, busy, in_ready);
            else n_pass++;
            @(posedge clk); #2;
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        int         w;
        pat = 7'b1101001;
        w = 0;
        in_data = BUS_A; in_mask = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = pat[c]; #1;
            n_total++;
            if ({out_valid, out_data, out_index, out_last, in_ready} !==
                {1'b1, exp_a[w], 2'(w), (w == 3), (pat[c] && (w == 3))})
                $display("FAIL bp_cycle%0d: got v=%b d=%h i=%0d l=%b r=%b, expected d=%h i=%0d",
                         c, out_valid, out_data, out_index, out_last, in_ready, exp_a[w], w);
            else n_pass++;
            @(posedge clk); #1;
            if (pat[c]) w++;
        end
        out_ready = 1'b1; #1;
        n_total++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL bp_done: got v=%b b=%b, expected 0 0", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        in_data = BUS_A; in_mask = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_data = BUS_B; #1;
        for (int c = 0; c < 8; c++) begin
            e = (c < 4) ? exp_a[c % 4] : exp_b[c % 4];
            n_total++;
            if ({out_valid, out_data, out_index, out_last, in_ready} !==
                {1'b1, e, 2'(c % 4), (c % 4 == 3), (c % 4 == 3)})
                $display("FAIL b2b_word%0d: got v=%b d=%h i=%0d l=%b r=%b, expected d=%h",
                         c, out_valid, out_data, out_index, out_last, in_ready, e);
            else n_pass++;
            @(posedge clk); #1;
            if (c == 3) in_valid = 1'b0;
            #1;
        end
        n_total++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL b2b_done: got v=%b b=%b, expected 0 0", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        in_data = BUS_A; in_mask = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        n_total++;
        if ({out_valid, out_data, out_index} !== {1'b1, 16'h89AB, 2'd2})
            $display("FAIL midrst_pre: got v=%b d=%h i=%0d, expected 1 89ab 2", out_valid, out_data, out_index);
        else n_pass++;
        reset_L = 1'b0; #1;
        n_total++;
        if ({out_valid, out_data, out_index, out_last, busy, in_ready} !== 22'h0)
            $display("FAIL midrst_async: got %h, expected 0",
                     {out_valid, out_data, out_index, out_last, busy, in_ready});
        else n_pass++;
        @(negedge clk); reset_L = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_total++;
            if ({out_valid, busy} !== 2'b00)
                $display("FAIL midrst_residual%0d: got v=%b b=%b d=%h, expected 0 0", k, out_valid, busy, out_data);
            else n_pass++;
        end
        in_data = BUS_B; in_mask = 4'b0110; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; #1;
        n_total++;
        if ({out_valid, out_data, out_index, out_last} !== {1'b1, 16'h89AB, 2'd1, 1'b0})
            $display("FAIL midrst_new0: got d=%h i=%0d l=%b, expected 89ab 1 0", out_data, out_index, out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if ({out_valid, out_data, out_index, out_last} !== {1'b1, 16'h4567, 2'd2, 1'b1})
            $display("FAIL midrst_new1: got d=%h i=%0d l=%b, expected 4567 2 1", out_data, out_index, out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL midrst_done: got v=%b, expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_param_sweep();
        p_in_data = {8'h33, 8'h22, 8'h11}; p_in_mask = 3'b101; p_in_valid = 1'b1; p_out_ready = 1'b1;
        @(posedge clk); #1; p_in_valid = 1'b0; #1;
        n_total++;
        if ({p_out_valid, p_out_data, p_out_index, p_out_last} !== {1'b1, 8'h11, 2'd0, 1'b0})
            $display("FAIL p3_w0: got v=%b d=%h i=%0d l=%b, expected 1 11 0 0",
                     p_out_valid, p_out_data, p_out_index, p_out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if ({p_out_valid, p_out_data, p_out_index, p_out_last} !== {1'b1, 8'h33, 2'd2, 1'b1})
            $display("FAIL p3_w1: got v=%b d=%h i=%0d l=%b, expected 1 33 2 1",
                     p_out_valid, p_out_data, p_out_index, p_out_last);
        else n_pass++;
        @(posedge clk); #2;
        n_total++;
        if ({p_out_valid, p_busy, p_out_data} !== 10'h0)
            $display("FAIL p3_done: got v=%b b=%b d=%h, expected 0 0 00", p_out_valid, p_busy, p_out_data);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_full_mask();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
